// File: rtl/bcd_sevenseg_scanner.sv
// Multiplexed driver for a four-digit common-anode seven-segment display.
// Latches a three-digit BCD value on load and scans it onto digits 0-2 with blanking.
module bcd_sevenseg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [1:0] hundreds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYCLES);
  localparam bit              LZ_EN     = (BLANK_LZ != 0);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    h_q;
  logic [3:0]    t_q;
  logic [3:0]    o_q;

  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic [3:0]    digit;
  logic          lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;  // non-BCD input shows a dash
    endcase
  endfunction

  // Next display value, built from the pre-edge scan position and latched digits.
  always_comb begin
    an_d     = 4'b1111;
    seg_d    = 7'h7F;
    digit    = o_q;
    lz_blank = 1'b0;
    case (idx)
      2'd1: begin
        digit    = t_q;
        lz_blank = LZ_EN && (h_q == 2'd0) && (t_q == 4'd0);
      end
      2'd2: begin
        digit    = {2'b00, h_q};
        lz_blank = LZ_EN && (h_q == 2'd0);
      end
      default: begin
        digit    = o_q;
        lz_blank = 1'b0;
      end
    endcase
    if ((cnt >= BLANK_END) && !lz_blank) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
      h_q <= 2'd0;
      t_q <= 4'd0;
      o_q <= 4'd0;
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (load) begin
        h_q <= hundreds;
        t_q <= tens;
        o_q <= ones;
      end
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Bench for bcd_sevenseg_scanner: three parameterisations share one stimulus stream,
// checked against fixed vector tables, hand sequences and an arithmetic display model.
module tb_bcd_sevenseg_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [1:0] hundreds;
  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int tests = 0;
  int fails = 0;

  // Model state: edges since reset and the digits the display should hold
  int         m_n = 0;
  logic [1:0] m_h = 2'd0;
  logic [3:0] m_t = 4'd0;
  logic [3:0] m_o = 4'd0;
  logic [10:0] exp_q[$];

  logic [6:0] seg_lut [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  localparam logic [10:0] BL = {4'b1111, 7'h7F};

  typedef struct {
    logic        rst;
    logic        ld;
    logic [1:0]  h;
    logic [3:0]  t;
    logic [3:0]  o;
    logic [10:0] exp_a;
    logic [10:0] exp_b;
  } vec_t;
  vec_t vecs[$];

  bcd_sevenseg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .ones(ones), .tens(tens),
    .hundreds(hundreds), .an(an_a), .seg(seg_a), .dp(dp_a));
  bcd_sevenseg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(1), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .ones(ones), .tens(tens),
    .hundreds(hundreds), .an(an_b), .seg(seg_b), .dp(dp_b));
  bcd_sevenseg_scanner #(.REFRESH_DIV(3), .BLANK_CYCLES(2), .BLANK_LZ(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .load(load), .ones(ones), .tens(tens),
    .hundreds(hundreds), .an(an_c), .seg(seg_c), .dp(dp_c));

  always #5 clk = ~clk;

  function automatic logic [10:0] pk(input logic [3:0] a, input logic [6:0] s);
    return {a, s};
  endfunction

  // Display seen after an edge whose pre-edge position is n edges into the scan
  function automatic logic [10:0] model_out(input int rd, input int bc, input int lz,
                                            input int n, input logic [1:0] h,
                                            input logic [3:0] t, input logic [3:0] o);
    int c;
    int i;
    logic [3:0] d;
    logic blank;
    c = n % rd;
    i = (n / rd) % 3;
    if (c < bc) return BL;
    d = (i == 0) ? o : (i == 1) ? t : {2'b00, h};
    blank = (lz != 0) && ((i == 2 && h == 2'd0) || (i == 1 && h == 2'd0 && t == 4'd0));
    if (blank) return BL;
    return {~(4'b0001 << i), (d > 4'd9) ? 7'h3F : seg_lut[d]};
  endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
               name, act[10:7], act[6:0], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic tick(input logic r, input logic ld, input logic [1:0] h,
                      input logic [3:0] t, input logic [3:0] o);
    rst_n = r; load = ld; hundreds = h; tens = t; ones = o;
    @(posedge clk);
    if (!r) begin
      repeat (3) exp_q.push_back(BL);
      m_n = 0; m_h = 2'd0; m_t = 4'd0; m_o = 4'd0;
    end else begin
      exp_q.push_back(model_out(4, 1, 1, m_n, m_h, m_t, m_o));
      exp_q.push_back(model_out(4, 1, 0, m_n, m_h, m_t, m_o));
      exp_q.push_back(model_out(3, 2, 1, m_n, m_h, m_t, m_o));
      if (ld) begin m_h = h; m_t = t; m_o = o; end
      m_n++;
    end
    #1;
    chk("model_a", {an_a, seg_a}, exp_q.pop_front());
    chk("model_b", {an_b, seg_b}, exp_q.pop_front());
    chk("model_c", {an_c, seg_c}, exp_q.pop_front());
    chk("dp", {8'd0, dp_a, dp_b, dp_c}, 11'd7);
  endtask

  task automatic add(input logic r, input logic ld, input logic [1:0] h, input logic [3:0] t,
                     input logic [3:0] o, input logic [10:0] ea, input logic [10:0] eb);
    vecs.push_back('{rst: r, ld: ld, h: h, t: t, o: o, exp_a: ea, exp_b: eb});
  endtask

  task automatic add_reset();
    repeat (3) add(1'b0, 1'b1, 2'd2, 4'd5, 4'd5, BL, BL);
  endtask

  task automatic add_slot(input logic [10:0] ea, input logic [10:0] eb);
    repeat (3) add(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, ea, eb);
    add(1'b1, 1'b0, 2'd0, 4'd0, 4'd0, BL, BL);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; ones = 4'd0; tens = 4'd0; hundreds = 2'd0;
    @(negedge clk);

    // Reset with load held high: digits must stay zero
    repeat (3) begin
      tick(1'b0, 1'b1, 2'd2, 4'd5, 4'd5);
      chk("reset_out", {an_a, seg_a}, BL);
    end
    tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("post_reset_blank", {an_a, seg_a}, BL);
    tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("post_reset_zero", {an_a, seg_a}, pk(4'b1110, 7'h40));

    // Vector tables: full value, leading zeros, invalid BCD
    add_reset();
    add(1'b1, 1'b1, 2'd2, 4'd5, 4'd5, BL, BL);
    add_slot(pk(4'b1110, 7'h12), pk(4'b1110, 7'h12));
    add_slot(pk(4'b1101, 7'h12), pk(4'b1101, 7'h12));
    add_slot(pk(4'b1011, 7'h24), pk(4'b1011, 7'h24));
    add_reset();
    add(1'b1, 1'b1, 2'd0, 4'd0, 4'd7, BL, BL);
    add_slot(pk(4'b1110, 7'h78), pk(4'b1110, 7'h78));
    add_slot(BL, pk(4'b1101, 7'h40));
    add_slot(BL, pk(4'b1011, 7'h40));
    add_reset();
    add(1'b1, 1'b1, 2'd1, 4'hC, 4'd3, BL, BL);
    add_slot(pk(4'b1110, 7'h30), pk(4'b1110, 7'h30));
    add_slot(pk(4'b1101, 7'h3F), pk(4'b1101, 7'h3F));
    add_slot(pk(4'b1011, 7'h79), pk(4'b1011, 7'h79));
    foreach (vecs[k]) begin
      tick(vecs[k].rst, vecs[k].ld, vecs[k].h, vecs[k].t, vecs[k].o);
      chk("table_a", {an_a, seg_a}, vecs[k].exp_a);
      chk("table_b", {an_b, seg_b}, vecs[k].exp_b);
    end

    // Load in the middle of the digit-0 slot
    repeat (2) tick(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b1, 2'd0, 4'd0, 4'd5);
    tick(1'b1, 1'b1, 2'd0, 4'd0, 4'd8);
    chk("midload_capture_edge", {an_a, seg_a}, pk(4'b1110, 7'h12));
    tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("midload_next_edge", {an_a, seg_a}, pk(4'b1110, 7'h00));

    // Reset during the digit-2 slot
    repeat (2) tick(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    tick(1'b1, 1'b1, 2'd1, 4'd2, 4'd3);
    repeat (9) tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("pre_reset_digit2", {an_a, seg_a}, pk(4'b1011, 7'h79));
    tick(1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("midscan_reset", {an_a, seg_a}, BL);
    tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("restart_blank", {an_a, seg_a}, BL);
    tick(1'b1, 1'b0, 2'd0, 4'd0, 4'd0);
    chk("restart_digit0", {an_a, seg_a}, pk(4'b1110, 7'h40));

    // Random loads and occasional resets against the model
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scanner.md
Name: bcd_sevenseg_scanner

Overview:
Time-multiplexed driver for the Basys 3 four-digit common-anode seven-segment display, placed directly downstream of the binary-to-BCD converter. It captures the converter's ones/tens/hundreds digits on a load strobe and scans them onto digits 0-2, with optional leading-zero blanking and anti-ghosting blank time. Digit 3 (leftmost) is always off. All display outputs are registered.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
BLANK_CYCLES, 16, cycles at the start of each slot during which all anodes are off; must be less than REFRESH_DIV.
BLANK_LZ, 1, 1 = blank leading zeros on hundreds/tens; 0 = always show all three digits.

Ports:
clk  input  1  system clock.
rst_n  input  1  synchronous active-low reset.
load  input  1  single-cycle strobe; captures ones/tens/hundreds when high.
ones  input  4  BCD units digit from the converter.
tens  input  4  BCD tens digit from the converter.
hundreds  input  2  BCD hundreds digit (0-2) from the converter.
an  output  4  anode enables, active-low; an[0] = rightmost digit.
seg  output  7  cathodes, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
dp  output  1  decimal point, active-low; held 1 (off) at all times.

Behaviour:
- Reset (rst_n low at a rising edge): an=4'b1111, seg=7'h7F, dp=1, slot counter cnt=0, digit index idx=0, latched digits = 0/0/0. Reset overrides load.
- Capture: on an edge with load=1, the registers h_q/t_q/o_q take hundreds/tens/ones. Without load they hold. Outputs reflect newly captured values from the following edge, so the latency is 1 cycle after the capture edge.
- Scan counter: cnt counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap edge, idx advances 0->1->2->0. idx never takes the value 3.
- Output register: each edge computes an/seg from the pre-edge cnt, idx and latched digits.
  - If cnt < BLANK_CYCLES: an=1111 and seg=7'h7F.
  - Otherwise, an = the one-hot-low code for idx (idx0 -> 1110, idx1 -> 1101, idx2 -> 1011), and seg = decode of the selected digit (idx0=o_q, idx1=t_q, idx2={2'b00,h_q}).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit 2 is blanked (an bit high, seg=7F) when h_q==0.
  - Digit 1 is blanked when h_q==0 and t_q==0.
  - Digit 0 is never blanked.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any digit value greater than 9 (only possible on t_q/o_q) shows a dash, seg=7'h3F.
- Simultaneous events: a load on a slot-wrap edge is legal. The new digit set appears one cycle later in whatever slot is active; no slot is skipped or extended.
- Reset mid-scan: reset forces the reset state on the next edge regardless of cnt/idx. Scanning restarts at idx=0 with a full blank interval.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, with load=1 during reset -> an=1111, seg=7F, dp=1. After release, latched digits remain 0 and the first displayed digit is idx0 showing '0' (seg=40).
- Full value (REFRESH_DIV=4, BLANK_CYCLES=1): load 2/5/5 -> the repeating 12-cycle pattern is (an,seg) = (1111,7F), 3x(1110,12), (1111,7F), 3x(1101,12), (1111,7F), 3x(1011,24).
- Leading zeros, BLANK_LZ=1: load 0/0/7 -> only digit 0 lights (an=1110, seg=78). Digit slots 1 and 2 show an=1111. With BLANK_LZ=0, digits 1 and 2 show seg=40.
- Invalid BCD: load tens=4'hC, ones=3, hundreds=1 -> digit 1 shows seg=3F, digit 0 shows 30, digit 2 shows 79.
- Load mid-slot: while digit 0 displays '5', pulse load with ones=8 -> seg changes to 00 exactly one cycle after the capture edge, and an is unchanged.
- Reset mid-scan: assert rst_n=0 during an idx=2 slot -> next edge gives an=1111, seg=7F. After release, the first lit digit is an=1110 after BLANK_CYCLES cycles.
